// File: rtl/midi_poly_synth.sv
// Polyphonic square-wave MIDI synthesiser: single-channel note-on/off parser, voice allocator
// with retrigger/free/steal priority, per-voice square-wave generators and a sample-rate mixer.
module midi_poly_synth #(
    parameter int VOICES     = 4,
    parameter int CHANNEL    = 0,
    parameter int OUT_W      = 16,
    parameter int SAMPLE_DIV = 1042
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              midi_data,
    input  logic                    midi_valid,
    output logic signed [OUT_W-1:0] sample_data,
    output logic                    sample_valid,
    output logic [VOICES-1:0]       voice_active
);

    localparam int SUM_W = 8 + $clog2(VOICES);
    localparam int SHIFT = OUT_W - SUM_W;
    localparam int PTR_W = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [3:0] CH_NIB = 4'(CHANNEL);

    typedef enum logic [1:0] {P_IDLE, P_NOTE, P_VEL, P_SKIP} parse_state_e;

    parse_state_e state_q, state_d;
    logic         rs_valid_q, rs_valid_d;
    logic         rs_on_q, rs_on_d;
    logic [6:0]   pnote_q, pnote_d;
    logic         ev_valid_q, ev_valid_d;
    logic         ev_on_q, ev_on_d;
    logic [6:0]   ev_note_q, ev_note_d;
    logic [6:0]   ev_vel_q, ev_vel_d;

    logic [VOICES-1:0] act_q, act_d;
    logic [VOICES-1:0] pol_q, pol_d;
    logic [6:0]        vnote_q [VOICES];
    logic [6:0]        vnote_d [VOICES];
    logic [6:0]        vvel_q  [VOICES];
    logic [6:0]        vvel_d  [VOICES];
    logic [21:0]       cnt_q   [VOICES];
    logic [21:0]       cnt_d   [VOICES];
    logic [PTR_W-1:0]  steal_q, steal_d;

    logic [DIV_W-1:0]        div_q, div_d;
    logic signed [OUT_W-1:0] sample_q, sample_d;
    logic                    svalid_q, svalid_d;

    logic                    match_hit, free_hit;
    logic [PTR_W-1:0]        match_idx, free_idx, tgt;
    logic signed [SUM_W-1:0] mix_sum;
    logic signed [OUT_W-1:0] mix_ext;
    logic                    div_tc;

    // Octave 10 uses the table directly; each lower octave doubles the half period.
    function automatic logic [21:0] half_period(input logic [6:0] n);
        logic [11:0] base;
        logic [3:0]  oct;
        logic [6:0]  semi;
        oct  = 4'(n / 7'd12);
        semi = n % 7'd12;
        case (semi)
            7'd0:    base = 12'd2986;
            7'd1:    base = 12'd2819;
            7'd2:    base = 12'd2660;
            7'd3:    base = 12'd2511;
            7'd4:    base = 12'd2370;
            7'd5:    base = 12'd2237;
            7'd6:    base = 12'd2112;
            7'd7:    base = 12'd1993;
            7'd8:    base = 12'd1881;
            7'd9:    base = 12'd1776;
            7'd10:   base = 12'd1676;
            default: base = 12'd1582;
        endcase
        return 22'(base) << (4'd10 - oct);
    endfunction

    always_comb begin
        state_d    = state_q;
        rs_valid_d = rs_valid_q;
        rs_on_d    = rs_on_q;
        pnote_d    = pnote_q;
        ev_valid_d = 1'b0;
        ev_on_d    = ev_on_q;
        ev_note_d  = ev_note_q;
        ev_vel_d   = ev_vel_q;
        if (midi_valid && midi_data < 8'hF8) begin
            if (midi_data[7]) begin
                if (midi_data == {4'h9, CH_NIB}) begin
                    state_d    = P_NOTE;
                    rs_valid_d = 1'b1;
                    rs_on_d    = 1'b1;
                end else if (midi_data == {4'h8, CH_NIB}) begin
                    state_d    = P_NOTE;
                    rs_valid_d = 1'b1;
                    rs_on_d    = 1'b0;
                end else begin
                    state_d    = P_SKIP;
                    rs_valid_d = 1'b0;
                end
            end else begin
                case (state_q)
                    P_IDLE: begin
                        if (rs_valid_q) begin
                            pnote_d = midi_data[6:0];
                            state_d = P_VEL;
                        end
                    end
                    P_NOTE: begin
                        pnote_d = midi_data[6:0];
                        state_d = P_VEL;
                    end
                    P_VEL: begin
                        ev_valid_d = 1'b1;
                        ev_on_d    = rs_on_q && (midi_data != 8'h00);
                        ev_note_d  = pnote_q;
                        ev_vel_d   = midi_data[6:0];
                        state_d    = P_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        act_d     = act_q;
        pol_d     = pol_q;
        vnote_d   = vnote_q;
        vvel_d    = vvel_q;
        cnt_d     = cnt_q;
        steal_d   = steal_q;
        match_hit = 1'b0;
        match_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        tgt       = '0;
        for (int i = 0; i < VOICES; i++) begin
            if (act_q[i]) begin
                if (cnt_q[i] == half_period(vnote_q[i]) - 22'd1) begin
                    cnt_d[i] = '0;
                    pol_d[i] = ~pol_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 22'd1;
                end
            end else begin
                cnt_d[i] = '0;
                pol_d[i] = 1'b0;
            end
        end
        // Scan downwards so the lowest matching/free index is the one that sticks.
        for (int i = VOICES - 1; i >= 0; i--) begin
            if (act_q[i] && vnote_q[i] == ev_note_q) begin
                match_hit = 1'b1;
                match_idx = PTR_W'(i);
            end
            if (!act_q[i]) begin
                free_hit = 1'b1;
                free_idx = PTR_W'(i);
            end
        end
        if (ev_valid_q) begin
            if (ev_on_q) begin
                if (match_hit) begin
                    tgt = match_idx;
                end else if (free_hit) begin
                    tgt = free_idx;
                end else begin
                    tgt     = steal_q;
                    steal_d = (steal_q == PTR_W'(VOICES - 1)) ? '0 : steal_q + PTR_W'(1);
                end
                act_d[tgt]   = 1'b1;
                vnote_d[tgt] = ev_note_q;
                vvel_d[tgt]  = ev_vel_q;
                cnt_d[tgt]   = '0;
                pol_d[tgt]   = 1'b0;
            end else begin
                for (int i = 0; i < VOICES; i++) begin
                    if (act_q[i] && vnote_q[i] == ev_note_q) begin
                        act_d[i] = 1'b0;
                        cnt_d[i] = '0;
                        pol_d[i] = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < VOICES; i++) begin
            if (act_q[i]) begin
                if (pol_q[i]) mix_sum = mix_sum - SUM_W'({1'b0, vvel_q[i]});
                else          mix_sum = mix_sum + SUM_W'({1'b0, vvel_q[i]});
            end
        end
        mix_ext  = OUT_W'(mix_sum);
        div_tc   = (div_q == DIV_W'(SAMPLE_DIV - 1));
        div_d    = div_tc ? '0 : div_q + DIV_W'(1);
        svalid_d = div_tc;
        sample_d = div_tc ? (mix_ext <<< SHIFT) : sample_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= P_IDLE;
            rs_valid_q <= 1'b0;
            rs_on_q    <= 1'b0;
            pnote_q    <= '0;
            ev_valid_q <= 1'b0;
            ev_on_q    <= 1'b0;
            ev_note_q  <= '0;
            ev_vel_q   <= '0;
            act_q      <= '0;
            pol_q      <= '0;
            steal_q    <= '0;
            div_q      <= '0;
            sample_q   <= '0;
            svalid_q   <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                vnote_q[i] <= '0;
                vvel_q[i]  <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            rs_valid_q <= rs_valid_d;
            rs_on_q    <= rs_on_d;
            pnote_q    <= pnote_d;
            ev_valid_q <= ev_valid_d;
            ev_on_q    <= ev_on_d;
            ev_note_q  <= ev_note_d;
            ev_vel_q   <= ev_vel_d;
            act_q      <= act_d;
            pol_q      <= pol_d;
            steal_q    <= steal_d;
            div_q      <= div_d;
            sample_q   <= sample_d;
            svalid_q   <= svalid_d;
            for (int i = 0; i < VOICES; i++) begin
                vnote_q[i] <= vnote_d[i];
                vvel_q[i]  <= vvel_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign sample_data  = sample_q;
    assign sample_valid = svalid_q;
    assign voice_active = act_q;

endmodule

// File: tb/tb_midi_poly_synth.sv
// Randomised bench for midi_poly_synth against a cycle-time reference model of voices,
// allocation and square-wave polarity derived from elapsed time since each trigger.
module tb_midi_poly_synth;
    localparam int VOICES     = 4;
    localparam int CHANNEL    = 0;
    localparam int OUT_W      = 16;
    localparam int SAMPLE_DIV = 64;
    localparam int SCALE      = 1 << (OUT_W - 8 - $clog2(VOICES));

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        midi_data = 8'h00;
    logic              midi_valid = 1'b0;
    logic [OUT_W-1:0]  sample_data;
    logic              sample_valid;
    logic [VOICES-1:0] voice_active;

    midi_poly_synth #(
        .VOICES(VOICES), .CHANNEL(CHANNEL), .OUT_W(OUT_W), .SAMPLE_DIV(SAMPLE_DIV)
    ) dut (
        .clk(clk), .rst(rst), .midi_data(midi_data), .midi_valid(midi_valid),
        .sample_data(sample_data), .sample_valid(sample_valid), .voice_active(voice_active)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    // Reference model
    int T [12] = '{2986, 2819, 2660, 2511, 2370, 2237, 2112, 1993, 1881, 1776, 1676, 1582};
    bit m_act  [VOICES];
    int m_note [VOICES];
    int m_vel  [VOICES];
    int m_t0   [VOICES];
    int m_steal;
    localparam int S_IDLE = 0, S_NOTE = 1, S_VEL = 2, S_SKIP = 3;
    int p_state, p_note;
    bit p_rs_valid, p_rs_on;

    function automatic int model_hp(int n);
        return T[n % 12] * (1 << (10 - n / 12));
    endfunction

    task automatic model_reset();
        for (int v = 0; v < VOICES; v++) m_act[v] = 1'b0;
        m_steal = 0; p_state = S_IDLE; p_note = 0; p_rs_valid = 1'b0; p_rs_on = 1'b0;
    endtask

    task automatic model_event(input bit on, input int n, input int vel, input int t0);
        int hit;
        hit = -1;
        if (on) begin
            for (int v = 0; v < VOICES; v++) if (hit < 0 && m_act[v] && m_note[v] == n) hit = v;
            for (int v = 0; v < VOICES; v++) if (hit < 0 && !m_act[v]) hit = v;
            if (hit < 0) begin
                hit = m_steal;
                m_steal = (m_steal + 1) % VOICES;
            end
            m_act[hit] = 1'b1; m_note[hit] = n; m_vel[hit] = vel; m_t0[hit] = t0;
        end else begin
            for (int v = 0; v < VOICES; v++) if (m_act[v] && m_note[v] == n) m_act[v] = 1'b0;
        end
    endtask

    // e = clock edge on which the byte was sampled; voices change on the following edge.
    task automatic model_byte(input int b, input int e);
        if (b >= 'hF8) begin
        end else if (b >= 'h80) begin
            if (b == ('h90 | CHANNEL)) begin
                p_state = S_NOTE; p_rs_valid = 1'b1; p_rs_on = 1'b1;
            end else if (b == ('h80 | CHANNEL)) begin
                p_state = S_NOTE; p_rs_valid = 1'b1; p_rs_on = 1'b0;
            end else begin
                p_state = S_SKIP; p_rs_valid = 1'b0;
            end
        end else begin
            if (p_state == S_IDLE && p_rs_valid) begin
                p_note = b; p_state = S_VEL;
            end else if (p_state == S_NOTE) begin
                p_note = b; p_state = S_VEL;
            end else if (p_state == S_VEL) begin
                model_event(p_rs_on && b != 0, p_note, b, e + 1);
                p_state = S_IDLE;
            end
        end
    endtask

    function automatic logic [VOICES-1:0] model_active();
        logic [VOICES-1:0] a;
        a = '0;
        for (int v = 0; v < VOICES; v++) a[v] = m_act[v];
        return a;
    endfunction

    // Sample registered on edge c reflects voice state after edge c-1.
    function automatic logic [OUT_W-1:0] model_mix(int c);
        int sum, k;
        sum = 0;
        for (int v = 0; v < VOICES; v++) begin
            if (m_act[v]) begin
                k = c - 1 - m_t0[v];
                if (((k / model_hp(m_note[v])) % 2) == 0) sum = sum + m_vel[v];
                else                                      sum = sum - m_vel[v];
            end
        end
        return OUT_W'(sum * SCALE);
    endfunction

    task automatic send_byte(input logic [7:0] b);
        midi_data  = b;
        midi_valid = 1'b1;
        @(negedge clk);
        midi_valid = 1'b0;
        model_byte(int'(b), cyc);
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send_byte(a); send_byte(b); send_byte(c);
        @(negedge clk);
    endtask

    task automatic send2(input logic [7:0] a, input logic [7:0] b);
        send_byte(a); send_byte(b);
        @(negedge clk);
    endtask

    task automatic wait_sample(output int c, output bit timed_out);
        timed_out = 1'b1;
        c = 0;
        for (int i = 0; i < 2 * SAMPLE_DIV + 2; i++) begin
            @(negedge clk);
            if (sample_valid) begin
                c = cyc;
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int r, c1, c2;
        bit to;
        repeat (3) @(negedge clk);
        n_total++;
        if (sample_data !== '0) $display("FAIL reset_data: got %h expected 0", sample_data); else n_pass++;
        n_total++;
        if (sample_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", sample_valid); else n_pass++;
        n_total++;
        if (voice_active !== '0) $display("FAIL reset_active: got %b expected 0", voice_active); else n_pass++;
        model_reset();
        rst = 1'b0;
        r = cyc;
        wait_sample(c1, to);
        n_total++;
        if (to || c1 - r != SAMPLE_DIV)
            $display("FAIL first_sample: got %0d edges (timeout %0b) expected %0d", c1 - r, to, SAMPLE_DIV);
        else n_pass++;
        wait_sample(c2, to);
        n_total++;
        if (to || c2 - c1 != SAMPLE_DIV)
            $display("FAIL sample_period: got %0d expected %0d", c2 - c1, SAMPLE_DIV);
        else n_pass++;
    endtask

    task automatic test_single_note();
        int c;
        bit to;
        do_reset();
        send3(8'h90, 8'h7F, 8'h64);
        n_total++;
        if (voice_active !== 4'b0001 || voice_active !== model_active())
            $display("FAIL single_active: got %b expected 0001", voice_active);
        else n_pass++;
        for (int s = 0; s < 70; s++) begin
            wait_sample(c, to);
            n_total++;
            if (to) $display("FAIL single_sample: no sample_valid within bound");
            else if (sample_data !== model_mix(c))
                $display("FAIL single_sample[%0d]: got %h expected %h", s, sample_data, model_mix(c));
            else n_pass++;
        end
    endtask

    task automatic test_running_status();
        int c;
        bit to;
        do_reset();
        send3(8'h90, 8'h3C, 8'h64);
        send2(8'h40, 8'h50);
        send2(8'h43, 8'h7F);
        n_total++;
        if (voice_active !== 4'b0111 || voice_active !== model_active())
            $display("FAIL rs_active: got %b expected 0111", voice_active);
        else n_pass++;
        send3(8'h80, 8'h40, 8'h00);
        n_total++;
        if (voice_active !== 4'b0101 || voice_active !== model_active())
            $display("FAIL rs_off: got %b expected 0101", voice_active);
        else n_pass++;
        for (int s = 0; s < 4; s++) begin
            wait_sample(c, to);
            n_total++;
            if (to) $display("FAIL rs_sample: no sample_valid within bound");
            else if (sample_data !== model_mix(c))
                $display("FAIL rs_sample[%0d]: got %h expected %h", s, sample_data, model_mix(c));
            else n_pass++;
        end
    endtask

    task automatic test_steal();
        int c;
        bit to;
        logic [7:0] notes [6];
        logic [7:0] vels [6];
        notes = '{8'h3C, 8'h3E, 8'h40, 8'h41, 8'h43, 8'h45};
        vels  = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send3(8'h90, notes[i], vels[i]);
            n_total++;
            if (voice_active !== model_active())
                $display("FAIL steal_active[%0d]: got %b expected %b", i, voice_active, model_active());
            else n_pass++;
            if (i >= 3) begin
                wait_sample(c, to);
                n_total++;
                if (to) $display("FAIL steal_sample: no sample_valid within bound");
                else if (sample_data !== model_mix(c))
                    $display("FAIL steal_sample[%0d]: got %h expected %h", i, sample_data, model_mix(c));
                else n_pass++;
            end
        end
    endtask

    task automatic test_retrigger();
        int c;
        bit to;
        do_reset();
        send3(8'h90, 8'h7F, 8'h64);
        repeat (1500) @(negedge clk);
        send3(8'h90, 8'h7F, 8'h20);
        n_total++;
        if (voice_active !== 4'b0001)
            $display("FAIL retrig_active: got %b expected 0001", voice_active);
        else n_pass++;
        for (int s = 0; s < 40; s++) begin
            wait_sample(c, to);
            n_total++;
            if (to) $display("FAIL retrig_sample: no sample_valid within bound");
            else if (sample_data !== model_mix(c))
                $display("FAIL retrig_sample[%0d]: got %h expected %h", s, sample_data, model_mix(c));
            else n_pass++;
        end
        send3(8'h90, 8'h7F, 8'h00);
        n_total++;
        if (voice_active !== 4'b0000)
            $display("FAIL vel0_active: got %b expected 0000", voice_active);
        else n_pass++;
        wait_sample(c, to);
        n_total++;
        if (to || sample_data !== '0)
            $display("FAIL vel0_sample: got %h (timeout %0b) expected 0", sample_data, to);
        else n_pass++;
    endtask

    task automatic test_filter();
        do_reset();
        send3(8'h91, 8'h3C, 8'h64);
        n_total++;
        if (voice_active !== 4'b0000) $display("FAIL wrong_channel: got %b expected 0000", voice_active);
        else n_pass++;
        send3(8'hA0, 8'h3C, 8'h64);
        n_total++;
        if (voice_active !== 4'b0000) $display("FAIL aftertouch: got %b expected 0000", voice_active);
        else n_pass++;
        send_byte(8'h90);
        send_byte(8'hF8);
        send3(8'h3C, 8'hFE, 8'h64);
        n_total++;
        if (voice_active !== 4'b0001) $display("FAIL realtime_note: got %b expected 0001", voice_active);
        else n_pass++;
        send_byte(8'hB0);
        send2(8'h3E, 8'h64);
        n_total++;
        if (voice_active !== 4'b0001) $display("FAIL rs_cleared: got %b expected 0001", voice_active);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        int r, c1, c2;
        bit to;
        do_reset();
        send3(8'h90, 8'h7F, 8'h64);
        wait_sample(c1, to);
        send_byte(8'h90);
        send_byte(8'h3C);
        rst = 1'b1;
        model_reset();
        #1;
        n_total++;
        if (voice_active !== '0 || sample_data !== '0 || sample_valid !== 1'b0)
            $display("FAIL async_reset: got active=%b data=%h valid=%b expected all 0",
                     voice_active, sample_data, sample_valid);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        r = cyc;
        send_byte(8'h64);
        @(negedge clk);
        n_total++;
        if (voice_active !== '0) $display("FAIL lone_velocity: got %b expected 0000", voice_active);
        else n_pass++;
        wait_sample(c1, to);
        n_total++;
        if (to || c1 - r != SAMPLE_DIV)
            $display("FAIL rst_first_sample: got %0d edges expected %0d", c1 - r, SAMPLE_DIV);
        else n_pass++;
        wait_sample(c2, to);
        n_total++;
        if (to || c2 - c1 != SAMPLE_DIV)
            $display("FAIL rst_period: got %0d expected %0d", c2 - c1, SAMPLE_DIV);
        else n_pass++;
    endtask

    task automatic test_random();
        int c, kind;
        bit to;
        logic [7:0] junk [5];
        junk = '{8'hA0, 8'hB0, 8'h91, 8'hF0, 8'h81};
        do_reset();
        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0: send_byte(8'h90);
                1: send_byte(8'h80);
                3: send_byte(junk[$urandom_range(0, 4)]);
                4: begin
                    send_byte(8'($urandom_range(8'hF8, 8'hFF)));
                    send_byte(8'h90);
                end
                default: ;
            endcase
            send_byte(8'($urandom_range(118, 127)));
            if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(8'hF8, 8'hFF)));
            send_byte(8'($urandom_range(0, 127)));
            @(negedge clk);
            n_total++;
            if (voice_active !== model_active())
                $display("FAIL rand_active[%0d]: got %b expected %b", it, voice_active, model_active());
            else n_pass++;
            if (it % 10 == 9) begin
                for (int s = 0; s < 8; s++) begin
                    wait_sample(c, to);
                    n_total++;
                    if (to) $display("FAIL rand_sample: no sample_valid within bound");
                    else if (sample_data !== model_mix(c))
                        $display("FAIL rand_sample[%0d.%0d]: got %h expected %h", it, s, sample_data, model_mix(c));
                    else n_pass++;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_note();
        test_running_status();
        test_steal();
        test_retrigger();
        test_filter();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
